// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: retires one Booth digit per clock and
// delivers a 2*WIDTH signed or unsigned product via a start/done handshake.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int AW = 2 * E;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   acc_reg, mcand_reg;
    logic [AW-1:0]   pp, acc_next;
    logic [E-1:0]    mult_reg;
    logic            prev_reg;
    logic [CW-1:0]   count_reg;
    logic            busy_reg, done_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic            load, last_digit;
    logic [2:0]      digit;

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign res_hi = hi_reg;
    assign res_lo = lo_reg;

    assign last_digit = (count_reg == CW'(N - 1));
    assign digit      = {mult_reg[1:0], prev_reg};

    // The multiplicand shifts left two bits per digit, so the partial product
    // is already aligned to weight 2i when it is added.
    always_comb begin
        pp = '0;
        case (digit)
            3'b001, 3'b010: pp = mcand_reg;
            3'b011:         pp = {mcand_reg[AW-2:0], 1'b0};
            3'b100:         pp = -{mcand_reg[AW-2:0], 1'b0};
            3'b101, 3'b110: pp = -mcand_reg;
            default:        pp = '0;
        endcase
        acc_next = acc_reg + pp;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            acc_reg   <= '0;
            mcand_reg <= '0;
            mult_reg  <= '0;
            prev_reg  <= 1'b0;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
            if (load) begin
                // Two extra operand bits let unsigned values use the signed recoding.
                acc_reg   <= '0;
                mcand_reg <= {{(AW-WIDTH){is_signed & M[WIDTH-1]}}, M};
                mult_reg  <= {{2{is_signed & Q[WIDTH-1]}}, Q};
                prev_reg  <= 1'b0;
                count_reg <= '0;
            end else if (state_reg == RUN) begin
                acc_reg   <= acc_next;
                mcand_reg <= {mcand_reg[AW-3:0], 2'b00};
                mult_reg  <= {2'b00, mult_reg[E-1:2]};
                prev_reg  <= mult_reg[1];
                count_reg <= count_reg + CW'(1);
                if (last_digit) begin
                    hi_reg <= acc_next[2*WIDTH-1:WIDTH];
                    lo_reg <= acc_next[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: a 32-bit and an 8-bit instance checked
// against a plain 2*WIDTH multiply of extended operands.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        clr, start, is_signed;
    logic [31:0] M, Q, res_hi, res_lo;
    logic        busy, done;
    logic        start8, is_signed8;
    logic [7:0]  M8, Q8, res_hi8, res_lo8;
    logic        busy8, done8;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [15:0] exp_q8[$];

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .clr(clr), .start(start), .is_signed(is_signed),
        .M(M), .Q(Q), .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .is_signed(is_signed8),
        .M(M8), .Q(Q8), .busy(busy8), .done(done8), .res_hi(res_hi8), .res_lo(res_lo8)
    );

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y;
        x = s ? {{32{a[31]}}, a} : {32'b0, a};
        y = s ? {{32{b[31]}}, b} : {32'b0, b};
        return x * y;
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] x, y;
        x = s ? {{8{a[7]}}, a} : {8'b0, a};
        y = s ? {{8{b[7]}}, b} : {8'b0, b};
        return x * y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the start edge; cyc ends as the cycle index of done.
    task automatic wait_done32(output int cyc, output int busy_cyc);
        cyc = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cyc++;
            step();
            cyc++;
        end
    endtask

    task automatic wait_done8(output int cyc, output int busy_cyc);
        cyc = 1;
        busy_cyc = 0;
        while (done8 !== 1'b1 && cyc < 200) begin
            if (busy8 === 1'b1) busy_cyc++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        start = 1'b0; is_signed = 1'b0; M = '0; Q = '0;
        start8 = 1'b0; is_signed8 = 1'b0; M8 = '0; Q8 = '0;
        repeat (3) step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_flags32 got=%b exp=00", {busy, done});
        end
        checks++;
        if ({res_hi, res_lo} !== 64'd0) begin
            errors++; $display("FAIL reset_res32 got=%h exp=0", {res_hi, res_lo});
        end
        checks++;
        if ({busy8, done8, res_hi8, res_lo8} !== 18'd0) begin
            errors++; $display("FAIL reset_all8 got=%h exp=0", {busy8, done8, res_hi8, res_lo8});
        end
        clr = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] ma [5] = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] qa [5] = '{32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [63:0] ex [5] = '{64'hFFFFFFFF_FFFFFFD6, 64'hFFFFFFFE_00000001, 64'h00000000_00000001,
                                64'h40000000_00000000, 64'hC0000000_80000000};
        int lat, bc;
        logic [63:0] e;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ex[i]);
            is_signed = sg[i]; M = ma[i]; Q = qa[i]; start = 1'b1;
            step();
            start = 1'b0;
            wait_done32(lat, bc);
            e = exp_q.pop_front();
            checks++;
            if ({res_hi, res_lo} !== e) begin
                errors++; $display("FAIL directed%0d_res got=%h exp=%h", i, {res_hi, res_lo}, e);
            end
            checks++;
            if (lat != 18) begin
                errors++; $display("FAIL directed%0d_latency got=%0d exp=18", i, lat);
            end
            checks++;
            if (bc != 17) begin
                errors++; $display("FAIL directed%0d_busy_cycles got=%0d exp=17", i, bc);
            end
            step();
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++; $display("FAIL directed%0d_done_width got=%b exp=00", i, {done, busy});
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat, bc, dones;
        logic [63:0] e;
        exp_q.push_back(64'd12);
        is_signed = 1'b1; M = 32'd3; Q = 32'd4; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; M = 32'd9; Q = 32'd9;
        step();
        start = 1'b0;
        wait_done32(lat, bc);
        e = exp_q.pop_front();
        checks++;
        if ({res_hi, res_lo} !== e) begin
            errors++; $display("FAIL ignore_start_res got=%h exp=%h", {res_hi, res_lo}, e);
        end
        exp_q.push_back(64'd25);
        start = 1'b1; M = 32'd5; Q = 32'd5;
        step();
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++; $display("FAIL back_to_back_restart got=%b exp=10", {busy, done});
        end
        start = 1'b0;
        wait_done32(lat, bc);
        lat = lat + 0;
        e = exp_q.pop_front();
        checks++;
        if ({res_hi, res_lo} !== e) begin
            errors++; $display("FAIL back_to_back_res got=%h exp=%h", {res_hi, res_lo}, e);
        end
        checks++;
        if (lat != 18) begin
            errors++; $display("FAIL back_to_back_latency got=%0d exp=18", lat);
        end
        dones = 0;
        repeat (25) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL ignore_start_extra_done got=%0d exp=0", dones);
        end
    endtask

    task automatic test_clr_abort();
        int lat, bc, dones;
        logic [63:0] e;
        is_signed = 1'b0; M = 32'd7; Q = 32'd11; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL abort_flags got=%b exp=00", {busy, done});
        end
        checks++;
        if ({res_hi, res_lo} !== 64'd0) begin
            errors++; $display("FAIL abort_res got=%h exp=0", {res_hi, res_lo});
        end
        dones = 0;
        repeat (25) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL abort_done_pulse got=%0d exp=0", dones);
        end
        exp_q.push_back(64'd6);
        is_signed = 1'b1; M = 32'd2; Q = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done32(lat, bc);
        e = exp_q.pop_front();
        checks++;
        if ({res_hi, res_lo} !== e || lat != 18) begin
            errors++; $display("FAIL after_abort_res got=%h lat=%0d exp=%h lat=18", {res_hi, res_lo}, lat, e);
        end
        step();
    endtask

    task automatic test_width8();
        int lat, bc;
        logic [15:0] e;
        logic s;
        logic [7:0] a, b;
        exp_q8.push_back(16'hFE01);
        is_signed8 = 1'b0; M8 = 8'hFF; Q8 = 8'hFF; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done8(lat, bc);
        e = exp_q8.pop_front();
        checks++;
        if ({res_hi8, res_lo8} !== e) begin
            errors++; $display("FAIL w8_ff_res got=%h exp=%h", {res_hi8, res_lo8}, e);
        end
        checks++;
        if (lat != 6 || bc != 5) begin
            errors++; $display("FAIL w8_latency got=%0d/%0d exp=6/5", lat, bc);
        end
        step();
        for (int i = 0; i < 200; i++) begin
            s = 1'($urandom_range(1, 0));
            a = 8'($urandom);
            b = 8'($urandom);
            exp_q8.push_back(ref8(s, a, b));
            is_signed8 = s; M8 = a; Q8 = b; start8 = 1'b1;
            step();
            start8 = 1'b0;
            wait_done8(lat, bc);
            e = exp_q8.pop_front();
            checks++;
            if ({res_hi8, res_lo8} !== e || lat != 6) begin
                errors++;
                $display("FAIL w8_rand%0d s=%b %h*%h got=%h lat=%0d exp=%h lat=6", i, s, a, b, {res_hi8, res_lo8}, lat, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [63:0] e;
        logic s;
        logic [31:0] a, b;
        logic [31:0] corner [4] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(1, 0));
            a = ($urandom_range(7, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom;
            b = ($urandom_range(7, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom;
            exp_q.push_back(ref32(s, a, b));
            is_signed = s; M = a; Q = b;
            step();
            wait_done32(lat, bc);
            e = exp_q.pop_front();
            checks++;
            if ({res_hi, res_lo} !== e || lat != 18) begin
                errors++;
                $display("FAIL b2b_rand%0d s=%b %h*%h got=%h lat=%0d exp=%h lat=18", i, s, a, b, {res_hi, res_lo}, lat, e);
            end
        end
        start = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_clr_abort();
        test_width8();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
